// File: rtl/tft_fb_arb.sv
// tft_fb_arb: single-port display RAM arbiter. TFT reads always win the slot,
// then posted host writes drain from a 2-entry buffer, then a single host read.
module tft_fb_arb #(
    parameter int AW    = 13,
    parameter int DW    = 8,
    parameter int DEPTH = 4800
) (
    input  logic          clk,
    input  logic          rst_x,
    input  logic          i_tft_rdreq,
    input  logic [AW-1:0] i_tft_raddr,
    output logic          o_tft_rdack,
    output logic [DW-1:0] o_tft_rdata,
    input  logic          i_host_wreq,
    input  logic [AW-1:0] i_host_waddr,
    input  logic [DW-1:0] i_host_wdata,
    output logic          o_host_wfull,
    output logic          o_host_wovf,
    input  logic          i_host_ovf_clr,
    input  logic          i_host_rreq,
    input  logic [AW-1:0] i_host_raddr,
    output logic          o_host_rbusy,
    output logic          o_host_rvld,
    output logic [DW-1:0] o_host_rdata,
    output logic          o_sram_ce,
    output logic          o_sram_we,
    output logic [AW-1:0] o_sram_addr,
    output logic [DW-1:0] o_sram_wdata,
    input  logic [DW-1:0] i_sram_rdata
);
    localparam logic [AW-1:0] LIM = AW'(DEPTH);

    typedef enum logic [1:0] {H_IDLE, H_WAIT, H_DATA} h_state_t;

    h_state_t      r_hst, w_hst_nxt;
    logic [AW-1:0] r_wq_addr [2];
    logic [DW-1:0] r_wq_data [2];
    logic          r_wp, r_rp;
    logic [1:0]    r_wcnt;
    logic          r_wovf, r_tpend, r_toor;
    logic [DW-1:0] r_tdata, r_hdata;
    logic [AW-1:0] r_haddr;
    logic          w_tft, w_push, w_pop, w_hgnt;
    logic          w_t_ok, w_wq_ok, w_h_ok;

    // TFT requests are masked during reset so the RAM port stays idle
    assign w_tft   = i_tft_rdreq & rst_x;
    assign w_push  = i_host_wreq & ~o_host_wfull;
    assign w_pop   = ~w_tft & (r_wcnt != 2'd0);
    assign w_hgnt  = ~w_tft & (r_wcnt == 2'd0) & (r_hst == H_WAIT);
    assign w_t_ok  = i_tft_raddr < LIM;
    assign w_wq_ok = r_wq_addr[r_rp] < LIM;
    assign w_h_ok  = r_haddr < LIM;

    assign o_tft_rdack  = w_tft;
    assign o_tft_rdata  = r_tpend ? (r_toor ? '0 : i_sram_rdata) : r_tdata;
    assign o_host_wfull = r_wcnt == 2'd2;
    assign o_host_wovf  = r_wovf;
    assign o_host_rdata = (r_hst == H_DATA) ? (w_h_ok ? i_sram_rdata : '0) : r_hdata;
    assign o_sram_ce    = (w_tft & w_t_ok) | (w_pop & w_wq_ok) | (w_hgnt & w_h_ok);
    assign o_sram_we    = w_pop & w_wq_ok;
    assign o_sram_addr  = w_tft ? i_tft_raddr : w_pop ? r_wq_addr[r_rp] : w_hgnt ? r_haddr : '0;
    assign o_sram_wdata = w_pop ? r_wq_data[r_rp] : '0;

    always_comb begin
        w_hst_nxt    = r_hst;
        o_host_rbusy = 1'b1;
        o_host_rvld  = 1'b0;
        case (r_hst)
            H_IDLE: begin
                o_host_rbusy = 1'b0;
                w_hst_nxt    = i_host_rreq ? H_WAIT : H_IDLE;
            end
            H_WAIT:  w_hst_nxt = w_hgnt ? H_DATA : H_WAIT;
            H_DATA: begin
                o_host_rvld = 1'b1;
                w_hst_nxt   = H_IDLE;
            end
            default: w_hst_nxt = H_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_hst   <= H_IDLE;
            r_haddr <= '0;
            r_hdata <= '0;
            r_tpend <= 1'b0;
            r_toor  <= 1'b0;
            r_tdata <= '0;
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
            r_wcnt  <= 2'd0;
            r_wovf  <= 1'b0;
        end else begin
            r_hst   <= w_hst_nxt;
            r_haddr <= (r_hst == H_IDLE && i_host_rreq) ? i_host_raddr : r_haddr;
            r_hdata <= o_host_rvld ? o_host_rdata : r_hdata;
            r_tpend <= w_tft;
            r_toor  <= ~w_t_ok;
            r_tdata <= r_tpend ? o_tft_rdata : r_tdata;
            r_wp    <= r_wp ^ w_push;
            r_rp    <= r_rp ^ w_pop;
            r_wcnt  <= r_wcnt + {1'b0, w_push} - {1'b0, w_pop};
            r_wovf  <= (i_host_wreq & o_host_wfull) | (r_wovf & ~i_host_ovf_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_wq_addr[r_wp] <= i_host_waddr;
            r_wq_data[r_wp] <= i_host_wdata;
        end
    end
endmodule
